// File: rtl/sign_extend_stream_pkg.sv
// -----------------------------------------------------------------------------
// sign_ext_pkg
// Mode encodings and the immediate-extension function shared by the
// sign_extend_stream datapath block.
//
// Optional feature macro: SIGN_EXT_SHL_EN
//   defined   : mode EXT_SHL sign-extends then shifts left by the shift amount
//   undefined : mode EXT_SHL behaves as EXT_SIGN, no shifter is built
// -----------------------------------------------------------------------------
package sign_ext_pkg;

  typedef enum logic [1:0] {
    EXT_ZERO = 2'd0,
    EXT_SIGN = 2'd1,
    EXT_ONES = 2'd2,
    EXT_SHL  = 2'd3
  } ext_mode_e;

  // Widest result the helper can produce; callers truncate to their OUT_W.
  localparam int unsigned EXT_MAX_W = 64;

  // Extend the low in_w bits of data to out_w bits according to mode.
  // Width arguments are elaboration constants at every call site, so the
  // masks and the shift reduce to wiring.
  function automatic logic [EXT_MAX_W-1:0] ext_imm(
    input logic [EXT_MAX_W-1:0] data,
    input ext_mode_e            mode,
    input int unsigned          in_w,
    input int unsigned          out_w
`ifdef SIGN_EXT_SHL_EN
    ,
    input int unsigned          shamt
`endif
  );
    logic [EXT_MAX_W-1:0] lo_mask;
    logic [EXT_MAX_W-1:0] out_mask;
    logic [EXT_MAX_W-1:0] hi_mask;
    logic [EXT_MAX_W-1:0] lo;
    logic [EXT_MAX_W-1:0] sext;
    logic [EXT_MAX_W-1:0] res;
    logic                 msb;

    lo_mask  = ~({EXT_MAX_W{1'b1}} << in_w);
    out_mask = (out_w >= EXT_MAX_W) ? {EXT_MAX_W{1'b1}}
                                    : ~({EXT_MAX_W{1'b1}} << out_w);
    hi_mask  = out_mask & ~lo_mask;
    lo       = data & lo_mask;
    // lo is masked, so after the shift only the immediate's MSB can remain.
    msb      = ((lo >> (in_w - 1)) != '0);
    sext     = msb ? (lo | hi_mask) : lo;

    case (mode)
      EXT_ZERO: res = lo;
      EXT_ONES: res = lo | hi_mask;
`ifdef SIGN_EXT_SHL_EN
      EXT_SHL:  res = (sext << shamt) & out_mask;
`endif
      default:  res = sext;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sign_extend_stream_fifo.sv
// -----------------------------------------------------------------------------
// ext_fifo
// Synchronous result buffer with occupancy count. The head entry is visible
// combinationally from the storage registers and reads as zero when empty.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (clears pointers/level)
//   i_push, i_pop  write / read requests; ignored when full / empty
//   i_wdata        entry to write
//   o_rdata_c      head entry, zero when empty
//   o_level        current occupancy (0..DEPTH)
//   o_full_c       level == DEPTH
//   o_empty_c      level == 0
// -----------------------------------------------------------------------------
module ext_fifo #(
  parameter int unsigned W     = 36,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_wdata,
  output logic [W-1:0]               o_rdata_c,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_full_c,
  output logic                       o_empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full_c  = (r_level == LVL_W'(DEPTH));
  assign o_empty_c = (r_level == '0);
  assign w_push    = i_push & ~o_full_c;
  assign w_pop     = i_pop & ~o_empty_c;
  assign o_level   = r_level;
  assign o_rdata_c = o_empty_c ? '0 : r_mem[r_rd_ptr];

  // Storage needs no reset: empty entries are never visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/sign_extend_stream.sv
// -----------------------------------------------------------------------------
// sign_extend_stream
// Pipelined immediate extender: narrow immediates arrive over valid/ready,
// are extended to OUT_W bits by a per-transaction mode and queued with their
// tag so decode can keep issuing while execute stalls.
//
// Optional feature macro: SIGN_EXT_SHL_EN (mode 3 = sign-extend then shift
// left by SHAMT; when undefined mode 3 behaves as SIGN).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake; in_ready = not full, low in reset
//   in_data, in_mode      immediate and extension mode (ZERO/SIGN/ONES/SHL)
//   in_tag                sideband tag returned with the result
//   out_valid / out_ready output handshake; out_valid = not empty
//   out_data, out_tag     head result, zero when empty
//   level                 buffer occupancy
// -----------------------------------------------------------------------------
module sign_extend_stream
  import sign_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 6,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned SHAMT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_data,
  input  logic [1:0]             in_mode,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic [TAG_W-1:0]       out_tag,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned ENT_W = OUT_W + TAG_W;

  if ((IN_W < 1) || (IN_W >= OUT_W) || (OUT_W > EXT_MAX_W) || (DEPTH < 2) ||
      ((DEPTH & (DEPTH - 1)) != 0) || (SHAMT >= OUT_W)) begin : g_bad_param
    $error("sign_extend_stream: illegal parameter combination");
  end

  ext_mode_e        w_mode;
  logic [OUT_W-1:0] w_ext;
  logic [ENT_W-1:0] w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_mode = ext_mode_e'(in_mode);
  assign w_ext  = OUT_W'(ext_imm(EXT_MAX_W'(in_data), w_mode, IN_W, OUT_W
`ifdef SIGN_EXT_SHL_EN
                                 , SHAMT
`endif
                                 ));

  // Gated by rst_n so the block refuses input while held in reset and is
  // ready as soon as reset is released.
  assign in_ready  = rst_n & ~w_full;
  assign out_valid = ~w_empty;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign out_data  = w_head[ENT_W-1:TAG_W];
  assign out_tag   = w_head[TAG_W-1:0];

  ext_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wdata   ({w_ext, in_tag}),
    .o_rdata_c (w_head),
    .o_level   (level),
    .o_full_c  (w_full),
    .o_empty_c (w_empty)
  );

endmodule

// File: tb/tb_sign_extend_stream.sv
// -----------------------------------------------------------------------------
// tb_sign_extend_stream
// Directed vector table, hand-written multi-cycle sequences and a randomized
// phase, all checked against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_sign_extend_stream;

  localparam int unsigned IN_W  = 6;
  localparam int unsigned OUT_W = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned SHAMT = 2;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic [LVL_W-1:0] level;

  always #5 clk = ~clk;

  sign_extend_stream #(
    .IN_W (IN_W), .OUT_W (OUT_W), .DEPTH (DEPTH), .TAG_W (TAG_W), .SHAMT (SHAMT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .level     (level)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference extension by plain integer arithmetic on the immediate value.
  function automatic logic [OUT_W-1:0] model_ext(input int unsigned d, input int unsigned m);
    longint span;
    longint sv;
    longint v;
    span = longint'(1) << IN_W;
    sv   = (longint'(d) >= span / 2) ? longint'(d) - span : longint'(d);
    case (m)
      0:       v = longint'(d);
      1:       v = sv;
      2:       v = longint'(d) - span;
`ifdef SIGN_EXT_SHL_EN
      default: v = sv * (longint'(1) << SHAMT);
`else
      default: v = sv;
`endif
    endcase
    return OUT_W'(v);
  endfunction

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t q[$];
  bit   m_push = 1'b0;
  bit   chk_en = 1'b0;

  // Reference buffer: pop then push, push only when the model has room.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_push = 1'b0;
    end else begin
      bit p;
      bit o;
      ent_t e;
      p = in_valid && (q.size() < int'(DEPTH));
      o = (q.size() != 0) && out_ready;
      if (o) void'(q.pop_front());
      if (p) begin
        e.data = model_ext(32'(in_data), 32'(in_mode));
        e.tag  = in_tag;
        q.push_back(e);
      end
      m_push = p;
    end
  end

  // Every cycle, mid-period: compare all outputs with the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [OUT_W-1:0] ed;
      logic [TAG_W-1:0] et;
      ed = '0;
      et = '0;
      if (q.size() != 0) begin
        ed = q[0].data;
        et = q[0].tag;
      end
      check("model_in_ready",  64'(in_ready),  64'(rst_n && (q.size() < int'(DEPTH))));
      check("model_out_valid", 64'(out_valid), 64'(q.size() != 0));
      check("model_level",     64'(level),     64'(q.size()));
      check("model_out_data",  64'(out_data),  64'(ed));
      check("model_out_tag",   64'(out_tag),   64'(et));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [IN_W-1:0]  d;
    logic [1:0]       m;
    logic [TAG_W-1:0] t;
    logic [OUT_W-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{6'd63, 2'd1, 4'h3, 32'hFFFF_FFFF};
    vecs[1] = '{6'd63, 2'd0, 4'h5, 32'h0000_003F};
    vecs[2] = '{6'd63, 2'd2, 4'h6, 32'hFFFF_FFFF};
    vecs[3] = '{6'd32, 2'd0, 4'h7, 32'h0000_0020};
`ifdef SIGN_EXT_SHL_EN
    vecs[4] = '{6'd32, 2'd3, 4'h8, 32'hFFFF_FF80};
    vecs[7] = '{6'd31, 2'd3, 4'hB, 32'h0000_007C};
`else
    vecs[4] = '{6'd32, 2'd3, 4'h8, 32'hFFFF_FFE0};
    vecs[7] = '{6'd31, 2'd3, 4'hB, 32'h0000_001F};
`endif
    vecs[5] = '{6'd31, 2'd1, 4'h9, 32'h0000_001F};
    vecs[6] = '{6'd0,  2'd2, 4'hA, 32'hFFFF_FFC0};

    // Reset held with in_valid asserted.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 6'd63;
    in_mode   = 2'd1;
    in_tag    = 4'h3;
    out_ready = 1'b0;
    chk_en    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_tag",   64'(out_tag),   64'd0);
    check("rst_level",     64'(level),     64'd0);
    #2 rst_n = 1'b1;
    #1 check("release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    check("first_push_level", 64'(level),     64'd1);
    check("first_push_valid", 64'(out_valid), 64'd1);
    check("first_push_data",  64'(out_data),  64'hFFFF_FFFF);
    check("first_push_tag",   64'(out_tag),   64'h3);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("first_drain_level", 64'(level), 64'd0);

    // Vector table, streaming one item per cycle.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = vecs[i].d;
      in_mode  = vecs[i].m;
      in_tag   = vecs[i].t;
      step();
      check("vec_data",  64'(out_data), 64'(vecs[i].exp));
      check("vec_tag",   64'(out_tag),  64'(vecs[i].t));
      check("vec_level", 64'(level),    64'd1);
    end
    in_valid = 1'b0;
    step();

    // Stall: three pushes into a two-entry buffer, then drain.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 6'd63; in_mode = 2'd1; in_tag = 4'h1;
    step();
    in_data = 6'd32; in_mode = 2'd0; in_tag = 4'h2;
    step();
    in_data = 6'd5;  in_mode = 2'd2; in_tag = 4'h3;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_level",    64'(level),    64'd2);
      check("stall_data",     64'(out_data), 64'hFFFF_FFFF);
      check("stall_tag",      64'(out_tag),  64'h1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    step();
    check("drain1_tag",      64'(out_tag),  64'h2);
    check("drain1_data",     64'(out_data), 64'h0000_0020);
    check("drain1_level",    64'(level),    64'd1);
    check("drain1_in_ready", 64'(in_ready), 64'd1);
    step();
    check("drain2_tag",   64'(out_tag),  64'h3);
    check("drain2_data",  64'(out_data), 64'hFFFF_FFC5);
    check("drain2_level", 64'(level),    64'd1);
    in_valid = 1'b0;
    step();
    check("drain3_valid", 64'(out_valid), 64'd0);
    check("drain3_data",  64'(out_data),  64'd0);

    // Continuous stream, then reset asserted mid-stream.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 6'(i * 9);
      in_mode = 2'(i);
      in_tag  = 4'(i + 4);
      step();
      check("burst_level", 64'(level),     64'd1);
      check("burst_valid", 64'(out_valid), 64'd1);
      check("burst_tag",   64'(out_tag),   64'(i + 4));
    end
    #3 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_level",     64'(level),     64'd0);
    check("midrst_out_data",  64'(out_data),  64'd0);
    check("midrst_out_tag",   64'(out_tag),   64'd0);
    check("midrst_in_ready",  64'(in_ready),  64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    in_valid = 1'b0;
    step();

    // Randomized traffic; the producer holds an item until it is accepted.
    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!(in_valid && !m_push)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = IN_W'($urandom);
        in_mode  = 2'($urandom);
        in_tag   = TAG_W'($urandom);
      end
      if (c < 200) out_ready = ($urandom_range(0, 2) != 0);
      else         out_ready = ($urandom_range(0, 3) == 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    check("final_empty", 64'(out_valid), 64'd0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
